// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder/loader: format class codes,
// RV32I opcodes (identical to those decoded by the main controller), forced
// funct3 values, the descriptor payload and the loader FSM states.
package instr_pkg;

  localparam int unsigned CNT_W = 11;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_JALR = 3'd2,
    CLS_LW   = 3'd3,
    CLS_S    = 3'd4,
    CLS_B    = 3'd5,
    CLS_U    = 3'd6,
    CLS_J    = 3'd7
  } instr_class_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  typedef struct packed {
    instr_class_e cls;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [31:0]  imm;
  } instr_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } load_state_e;

endpackage

// File: rtl/instr_packer.sv
// Combinational descriptor-to-RV32I word encoder.
// Ports: desc_i - decoded instruction descriptor; word_o - packed 32-bit word.
module instr_packer
  import instr_pkg::*;
(
  input  instr_desc_t desc_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    unique case (desc_i.cls)
      CLS_R:    word_o = {desc_i.funct7, desc_i.rs2, desc_i.rs1, desc_i.funct3,
                          desc_i.rd, OPC_OP};
      CLS_I:    word_o = {desc_i.imm[11:0], desc_i.rs1, desc_i.funct3,
                          desc_i.rd, OPC_OP_IMM};
      CLS_JALR: word_o = {desc_i.imm[11:0], desc_i.rs1, F3_JALR,
                          desc_i.rd, OPC_JALR};
      CLS_LW:   word_o = {desc_i.imm[11:0], desc_i.rs1, F3_LW,
                          desc_i.rd, OPC_LOAD};
      CLS_S:    word_o = {desc_i.imm[11:5], desc_i.rs2, desc_i.rs1, desc_i.funct3,
                          desc_i.imm[4:0], OPC_STORE};
      // Branch/jump offsets are halfword aligned; imm[0] is dropped.
      CLS_B:    word_o = {desc_i.imm[12], desc_i.imm[10:5], desc_i.rs2, desc_i.rs1,
                          desc_i.funct3, desc_i.imm[4:1], desc_i.imm[11], OPC_BRANCH};
      CLS_U:    word_o = {desc_i.imm[31:12], desc_i.rd, OPC_LUI};
      CLS_J:    word_o = {desc_i.imm[20], desc_i.imm[10:1], desc_i.imm[11],
                          desc_i.imm[19:12], desc_i.rd, OPC_JAL};
      default:  word_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs a stream of instruction descriptors into RV32I words and writes them
// sequentially into instruction memory from a latched base address.
// Ports: clk/rst (sync, active-high); start+base_addr open a session;
// in_* descriptor stream with valid/ready/last; mem_* write port with
// mem_ready backpressure; busy/done/count/err session status.
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              err
);

  load_state_e       state_q, state_d;
  logic [AW-1:0]     base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  instr_desc_t       desc;
  logic [31:0]       packed_word;
  logic              accept;
  logic              handshake;
  logic [CNT_W-1:0]  slot_idx;
  logic              slot_full;

  assign desc = '{cls: instr_class_e'(in_type), rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                  funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  instr_packer u_packer (
    .desc_i (desc),
    .word_o (packed_word)
  );

  // The output stage frees up in the same cycle its pending write is taken.
  assign in_ready  = (state_q == ST_LOAD) && (!mem_we_q || mem_ready);
  assign handshake = in_valid && in_ready;
  assign accept    = mem_we_q && mem_ready;

  // Slot for a new word: a pending write (being accepted now) already owns count_q.
  assign slot_idx  = count_q + CNT_W'(mem_we_q);
  assign slot_full = (slot_idx >= CNT_W'(DEPTH));

  // Next-state, counter and output-stage logic.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    err_d       = err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;

    if (accept) begin
      count_d  = count_q + CNT_W'(1);
      mem_we_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          count_d = '0;
          err_d   = 1'b0;
          base_d  = base_addr & ~AW'(3);
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          if (slot_full) begin
            err_d = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = base_q + (AW'(slot_idx) << 2);
            mem_wdata_d = packed_word;
          end
          if (in_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!mem_we_q || mem_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus randomized sessions,
// checked against a transaction-level model of the write stream.
module tb_instr_encoder_loader;
  import instr_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst, start, in_valid, in_ready, in_last, mem_we, mem_ready;
  logic        busy, done, err;
  logic [31:0] base_addr, in_imm, mem_addr, mem_wdata;
  logic [2:0]  in_type, in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [6:0]  in_funct7;
  logic [10:0] count;

  instr_encoder_loader #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: session phase, pending write, counters.
  bit          m_load, m_drain, m_pend, m_err, m_hs, m_done;
  int          m_count, m_issued, cyc, done_cnt;
  logic [31:0] m_base, m_paddr, m_pdata;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RV32I encoding computed arithmetically from the field layout.
  function automatic logic [31:0] ref_pack(input logic [2:0] cls, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
      input logic [31:0] f7, input logic [31:0] imm);
    logic [31:0] regs;
    regs = (rs1 << 15) | (rd << 7);
    case (cls)
      3'd0: return (f7 << 25) | (rs2 << 20) | (f3 << 12) | regs | 32'd51;
      3'd1: return ((imm & 32'hFFF) << 20) | (f3 << 12) | regs | 32'd19;
      3'd2: return ((imm & 32'hFFF) << 20) | regs | 32'd103;
      3'd3: return ((imm & 32'hFFF) << 20) | (32'd2 << 12) | regs | 32'd3;
      3'd4: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((imm & 32'h1F) << 7) | 32'd35;
      3'd5: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 32'h1) << 7) | 32'd99;
      3'd6: return (imm & 32'hFFFFF000) | (rd << 7) | 32'd55;
      default: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (rd << 7) | 32'd111;
    endcase
  endfunction

  // One clock: check outputs against the model, advance both by one edge.
  task automatic tick();
    bit exp_rdy, acc, hs, fin, was_idle;
    #1;
    cyc++;
    acc = 0; hs = 0; fin = 0;
    was_idle = !m_load && !m_drain;
    if (!rst) begin
      exp_rdy = m_load && (!m_pend || mem_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("mem_we", 32'(mem_we), 32'(m_pend));
      if (m_pend) begin
        chk("mem_addr", mem_addr, m_paddr);
        chk("mem_wdata", mem_wdata, m_pdata);
      end
      acc = m_pend && mem_ready;
      hs  = in_valid && exp_rdy;
      fin = m_drain && (!m_pend || mem_ready);
      if (acc) begin
        obs_addr.push_back(mem_addr);
        obs_data.push_back(mem_wdata);
        obs_cyc.push_back(cyc);
      end
    end
    m_hs = hs;
    @(posedge clk);
    #1;
    if (rst) begin
      m_load = 0; m_drain = 0; m_pend = 0; m_err = 0; m_count = 0; m_issued = 0;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
    end else begin
      if (acc) begin m_count++; m_pend = 0; end
      if (hs) begin
        if (m_issued < DEPTH) begin
          m_pend  = 1;
          m_paddr = m_base + 32'(4 * m_issued);
          m_pdata = ref_pack(in_type, 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                             32'(in_funct3), 32'(in_funct7), in_imm);
          m_issued++;
        end else begin
          m_err = 1;
        end
        if (in_last) begin m_load = 0; m_drain = 1; end
      end
      m_done = fin;
      if (fin) m_drain = 0;
      if (start && was_idle) begin
        m_load = 1; m_count = 0; m_issued = 0; m_err = 0;
        m_base = base_addr & ~32'd3;
      end
      if (done === 1'b1) done_cnt++;
      chk("done", 32'(done), 32'(m_done));
      chk("busy", 32'(busy), 32'(m_load || m_drain));
      chk("count", 32'(count), 32'(m_count));
      chk("err", 32'(err), 32'(m_err));
    end
  endtask

  task automatic set_desc(input instr_class_e cls, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input bit last);
    in_type = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
  endtask

  task automatic send(input instr_class_e cls, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input bit last);
    int n;
    set_desc(cls, rd, rs1, rs2, f3, f7, imm, last);
    in_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!m_hs && n < 50);
    checks++;
    assert (m_hs) else begin
      failures++;
      $error("FAIL send_timeout observed=no_handshake expected=handshake");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    mem_ready = 1'b1;
    while ((m_load || m_drain) && n < 50) begin tick(); n++; end
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_start(input logic [31:0] base);
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    done_cnt  = 0;
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int n, sent;
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; mem_ready = 1'b1;
    set_desc(CLS_R, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;

    // Single I-type word at 0x100.
    do_start(32'h100);
    send(CLS_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1);
    wait_idle();
    chk("i_nwrites", 32'(obs_data.size()), 32'd1);
    chk("i_word", obs_data[0], 32'h00500093);
    chk("i_addr", obs_addr[0], 32'h100);
    chk("i_count", 32'(count), 32'd1);
    chk("i_done", 32'(done_cnt), 32'd1);

    // S then B back to back, base low bits ignored.
    do_start(32'h203);
    send(CLS_S, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 0);
    send(CLS_B, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1);
    wait_idle();
    chk("sb_nwrites", 32'(obs_data.size()), 32'd2);
    chk("s_word", obs_data[0], 32'h0020A423);
    chk("b_word", obs_data[1], 32'hFE208EE3);
    chk("s_addr", obs_addr[0], 32'h200);
    chk("b_addr", obs_addr[1], 32'h204);
    chk("sb_consecutive", 32'(obs_cyc[1] - obs_cyc[0]), 32'd1);

    // J then U with the first write stalled for 3 cycles.
    do_start(32'h300);
    send(CLS_J, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 0);
    mem_ready = 1'b0;
    set_desc(CLS_U, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1);
    in_valid = 1'b1;
    repeat (3) tick();
    chk("stall_we", 32'(mem_we), 32'd1);
    chk("stall_data", mem_wdata, 32'h008000EF);
    mem_ready = 1'b1;
    send(CLS_U, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1);
    wait_idle();
    chk("ju_nwrites", 32'(obs_data.size()), 32'd2);
    chk("j_word", obs_data[0], 32'h008000EF);
    chk("u_word", obs_data[1], 32'h123452B7);
    chk("u_addr", obs_addr[1], 32'h304);

    // Overflow: six descriptors into a four-word window.
    do_start(32'h40);
    for (int i = 0; i < 6; i++) begin
      send(CLS_I, 5'(i), 5'd3, 5'd0, 3'd1, 7'd0, 32'(i), i == 5);
      if (i == 3) chk("ovf_err_before", 32'(err), 32'd0);
      if (i == 4) chk("ovf_err_after5", 32'(err), 32'd1);
    end
    wait_idle();
    chk("ovf_nwrites", 32'(obs_data.size()), 32'd4);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_done", 32'(done_cnt), 32'd1);

    // Reset while a write is pending, then restart at base 0.
    do_start(32'h300);
    mem_ready = 1'b0;
    send(CLS_LW, 5'd7, 5'd2, 5'd0, 3'd0, 7'd0, 32'd12, 0);
    tick();
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    do_start(32'h0);
    send(CLS_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 1);
    wait_idle();
    chk("rst_resume_addr", obs_addr[0], 32'h0);
    chk("rst_resume_word", obs_data[0], 32'h402081B3);

    // start during LOAD is ignored.
    do_start(32'h400);
    send(CLS_JALR, 5'd1, 5'd5, 5'd0, 3'd7, 7'd0, 32'hFFC, 0);
    start = 1'b1; base_addr = 32'h800;
    tick();
    start = 1'b0;
    send(CLS_I, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1, 1);
    wait_idle();
    chk("ign_addr0", obs_addr[0], 32'h400);
    chk("ign_addr1", obs_addr[1], 32'h404);
    chk("ign_count", 32'(count), 32'd2);

    // Randomized sessions with random valid and mem_ready backpressure.
    for (int s = 0; s < 40; s++) begin
      do_start($urandom);
      n = $urandom_range(1, 7);
      sent = 0;
      for (int c = 0; c < 300 && sent < n; c++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        set_desc(instr_class_e'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), $urandom, sent == n - 1);
        mem_ready = ($urandom_range(0, 3) != 0);
        tick();
        if (m_hs) sent++;
      end
      in_valid = 1'b0;
      chk("rnd_sent", 32'(sent), 32'(n));
      wait_idle();
      chk("rnd_count", 32'(count), 32'(n < DEPTH ? n : DEPTH));
      chk("rnd_err", 32'(err), 32'(n > DEPTH));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Writer-side counterpart of the instruction decode path: accepts a stream of decoded instruction descriptors (format class plus fields) and packs each into a 32-bit RV32I word.
- Writes the packed words sequentially into instruction memory, starting at a programmable base address.
- Used by the bench and by the boot/program-load path to build programs.
- The opcode for each class is exactly the one the main controller decodes, so load-then-execute round-trips.

Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words; the write window is DEPTH words from base.
- AW, 32, byte-address width of mem_addr.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches base_addr and begins a load session
- base_addr  in  AW  byte base address; bits [1:0] are ignored (forced to 0)
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_last  in  1  marks the final descriptor of the session
- in_type  in  3  format class (see package)
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field
- in_imm  in  32  immediate, sign-extended, byte offset
- mem_we  out  1  write strobe to instruction memory
- mem_addr  out  AW  byte address of the write
- mem_wdata  out  32  packed instruction word
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready
- busy  out  1  session active
- done  out  1  one-cycle pulse after the last write completes
- count  out  11  number of words written in this session
- err  out  1  sticky overflow flag

Behaviour:
- Reset: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, count=0, err=0. Reset mid-session abandons it; a pending write is dropped.
- FSM states: IDLE, LOAD, DRAIN.
  - IDLE -> LOAD on start: clear count and err; base <= {base_addr[AW-1:2],2'b00}.
  - LOAD -> DRAIN on a handshake with in_last=1.
  - DRAIN -> IDLE when the final write is accepted (or no write is pending); done pulses for 1 cycle on that transition.
- start while not IDLE is ignored.
- in_ready = (state==LOAD) && (!mem_we || mem_ready).
- Single registered output stage: a handshake in cycle N gives mem_we=1, mem_wdata=packed, mem_addr=base+4*count in cycle N+1.
- mem_we, mem_addr and mem_wdata hold stable while mem_ready=0.
- count increments when each write is accepted.
- Back-to-back handshakes give one write per cycle when mem_ready=1.
- Overflow: a descriptor accepted when count==DEPTH is consumed but not written; err is set and stays set until the next start. in_last still ends the session.
- Packing (opcode fixed per class):
  - R: {f7,rs2,rs1,f3,rd,0110011}
  - I: {imm[11:0],rs1,f3,rd,0010011}
  - JALR: {imm[11:0],rs1,000,rd,1100111}
  - LW: {imm[11:0],rs1,010,rd,0000011}; funct3 forced
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],0100011}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011}
  - U: {imm[31:12],rd,0110111}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}
- Unused fields are ignored. imm bit 0 is ignored for B and J.

Decomposition:
- Package instr_pkg holds:
  - class codes: R=0, I=1, JALR=2, LW=3, S=4, B=5, U=6, J=7;
  - the 7-bit opcode constants matching those decoded by the main controller;
  - the LW funct3 constant.
- One sub-module, instr_packer: a purely combinational descriptor-to-word encoder. The FSM, counter and output register live in the top.

Test Plan:
- start base=0x100; I rd=1 rs1=0 f3=0 imm=5, last -> one write mem_addr=0x100, mem_wdata=0x00500093; done pulses; count=1.
- S rs1=1 rs2=2 f3=2 imm=8, then B rs1=1 rs2=2 f3=0 imm=-4 (last) -> writes 0x0020A423 @base+0 and 0xFE208EE3 @base+4, on consecutive cycles.
- J rd=1 imm=8, then U rd=5 imm=0x12345000 -> writes 0x008000EF and 0x123452B7. Hold mem_ready=0 for 3 cycles on the first: mem_* stay stable, in_ready=0, no word is lost.
- DEPTH=4; send 6 descriptors -> exactly 4 writes, err=1 after the 5th, count=4, done still pulses.
- Assert rst during LOAD with mem_we=1 -> next cycle all outputs are at reset values; a new start with base=0 resumes at address 0.
- start pulsed during LOAD -> ignored; base and count unchanged.
